bypass_rf_mp: RTL and testbench

- Multi-channel successor to the two-reader bypass register file, used in PDL-generated pipelines for renamed register reads with in-order write reservation.
- Provides NUM_RD independent read channels, each a reservation FIFO of depth RD_DEPTH, plus an in-order write-name queue and two write ports.
- Every pending read entry, not only the FIFO head, snoops the write ports. A FLUSH input cancels all outstanding reservations.

---
 rtl/bypass_rf_mp_if.sv | 43 ++++
 rtl/bypass_rf_mp.sv | 235 +++++++++++++++++++++++
 tb/tb_bypass_rf_mp.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/bypass_rf_mp_if.sv
// Bus interface for bypass_rf_mp.
// Groups every non-clock/reset signal of the register file:
//   write reservation : ALLOC_E, ADDR_IN -> ALLOC_READY, NAME_OUT
//   read reservation  : RRESE, RADDR     -> RRES_READY
//   write ports       : WE, W_NAME, D_IN (two ports, port 1 has priority)
//   read heads        : D_OUT, VALID_OUT, popped by RFREE_E
//   in-order free     : WFE, W_F         -> F_READY
//   FLUSH             : cancels all reservations
// master = pipeline side driving requests, slave = the register file.
interface bypass_rf_mp_if #(
    parameter int addr_width = 5,
    parameter int data_width = 32,
    parameter int name_width = 3,
    parameter int NUM_RD     = 3
);
    logic                                 ALLOC_E;
    logic [addr_width-1:0]                ADDR_IN;
    logic                                 ALLOC_READY;
    logic [name_width-1:0]                NAME_OUT;
    logic [NUM_RD-1:0]                    RRESE;
    logic [NUM_RD-1:0][addr_width-1:0]    RADDR;
    logic [NUM_RD-1:0]                    RRES_READY;
    logic [1:0]                           WE;
    logic [1:0][name_width-1:0]           W_NAME;
    logic [1:0][data_width-1:0]           D_IN;
    logic [NUM_RD-1:0][data_width-1:0]    D_OUT;
    logic [NUM_RD-1:0]                    VALID_OUT;
    logic [NUM_RD-1:0]                    RFREE_E;
    logic                                 WFE;
    logic [name_width-1:0]                W_F;
    logic                                 F_READY;
    logic                                 FLUSH;

    modport master (
        output ALLOC_E, ADDR_IN, RRESE, RADDR, WE, W_NAME, D_IN, RFREE_E, WFE, W_F, FLUSH,
        input  ALLOC_READY, NAME_OUT, RRES_READY, D_OUT, VALID_OUT, F_READY
    );

    modport slave (
        input  ALLOC_E, ADDR_IN, RRESE, RADDR, WE, W_NAME, D_IN, RFREE_E, WFE, W_F, FLUSH,
        output ALLOC_READY, NAME_OUT, RRES_READY, D_OUT, VALID_OUT, F_READY
    );
endinterface

// File: rtl/bypass_rf_mp.sv
// Multi-channel bypass register file with in-order write reservation.
//   CLK, RST (async, active low) and a bypass_rf_mp_if.slave bus.
// A circular write-name queue hands out names to writers in order and frees
// them in order. Each of NUM_RD read channels is a RD_DEPTH-deep FIFO of
// reservations; every not-yet-valid entry snoops both write ports, and the
// FIFO head additionally forwards a same-cycle write combinationally.
// The rf array itself has no reset; binaryInit/file describe how the
// simulation environment preloads it at time zero.

// One read channel: reservation FIFO with per-entry write snooping.
//   push/push_valid/push_name/push_data : new reservation (lookup done by parent)
//   pop, flush                           : head pop, cancel everything
//   we/w_name/d_in                       : write ports being snooped
//   ready, valid_out, d_out              : not full, head valid, head data
module bypass_rf_mp_chan #(
    parameter int data_width = 32,
    parameter int name_width = 3,
    parameter int RD_DEPTH   = 4
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             flush,
    input  logic                             push,
    input  logic                             push_valid,
    input  logic [name_width-1:0]            push_name,
    input  logic [data_width-1:0]            push_data,
    input  logic                             pop,
    input  logic [1:0]                       we,
    input  logic [1:0][name_width-1:0]       w_name,
    input  logic [1:0][data_width-1:0]       d_in,
    output logic                             ready,
    output logic                             valid_out,
    output logic [data_width-1:0]            d_out
);
    localparam int PW = $clog2(RD_DEPTH);
    localparam int CW = PW + 1;

    logic [RD_DEPTH-1:0][data_width-1:0] e_data;
    logic [RD_DEPTH-1:0][name_width-1:0] e_name;
    logic [RD_DEPTH-1:0]                 e_valid;
    logic [PW-1:0]                       rd_ptr, wr_ptr;
    logic [CW-1:0]                       count;
    logic                                push_fire, pop_fire;
    logic [RD_DEPTH-1:0]                 hit0, hit1;

    // Full is judged on the registered count, so a full FIFO refuses a
    // reservation even when it pops in the same cycle.
    assign ready     = (count != CW'(RD_DEPTH));
    assign push_fire = push && ready && !flush;
    assign pop_fire  = pop && (count != '0) && !flush;

    always_comb begin
        hit0 = '0;
        hit1 = '0;
        for (int i = 0; i < RD_DEPTH; i++) begin
            hit0[i] = we[0] && (w_name[0] == e_name[i]);
            hit1[i] = we[1] && (w_name[1] == e_name[i]);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            e_data  <= '0;
            e_name  <= '0;
            e_valid <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
        end else if (flush) begin
            e_valid <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
        end else begin
            // Stale (unoccupied) slots may snoop too; a push overwrites them.
            for (int i = 0; i < RD_DEPTH; i++) begin
                if (!e_valid[i] && (hit0[i] || hit1[i])) begin
                    e_valid[i] <= 1'b1;
                    e_data[i]  <= hit1[i] ? d_in[1] : d_in[0];
                end
            end
            // The parent already folded a same-cycle write into push_data.
            if (push_fire) begin
                e_valid[wr_ptr] <= push_valid;
                e_data[wr_ptr]  <= push_data;
                e_name[wr_ptr]  <= push_name;
                wr_ptr          <= wr_ptr + PW'(1);
            end
            if (pop_fire) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push_fire) - CW'(pop_fire);
        end
    end

    always_comb begin
        valid_out = 1'b0;
        d_out     = '0;
        if (count != '0) begin
            if (e_valid[rd_ptr]) begin
                valid_out = 1'b1;
                d_out     = e_data[rd_ptr];
            end else if (hit1[rd_ptr]) begin
                valid_out = 1'b1;
                d_out     = d_in[1];
            end else if (hit0[rd_ptr]) begin
                valid_out = 1'b1;
                d_out     = d_in[0];
            end
        end
    end
endmodule

module bypass_rf_mp #(
    parameter int    addr_width = 5,
    parameter int    data_width = 32,
    parameter int    name_width = 3,
    parameter int    NUM_RD     = 3,
    parameter int    RD_DEPTH   = 4,
    parameter int    binaryInit = 0,
    parameter string file       = ""
) (
    input  logic           CLK,
    input  logic           RST,
    bypass_rf_mp_if.slave  bus
);
    localparam int Q       = 1 << name_width;
    localparam int RF_SIZE = 1 << addr_width;

    logic [data_width-1:0]           rf [RF_SIZE];
    logic [Q-1:0]                    q_valid, q_written;
    logic [Q-1:0][addr_width-1:0]    q_addr;
    logic [name_width-1:0]           head, owner;
    logic                            alloc_rdy, free_rdy, alloc_fire, free_fire;

    assign alloc_rdy       = !q_valid[head];
    assign free_rdy        = q_valid[owner] && (bus.W_F == owner);
    assign alloc_fire      = bus.ALLOC_E && alloc_rdy && !bus.FLUSH;
    assign free_fire       = bus.WFE && free_rdy && !bus.FLUSH;
    assign bus.ALLOC_READY = alloc_rdy;
    assign bus.NAME_OUT    = head;
    assign bus.F_READY     = free_rdy;

    // Write-name queue. Write marks go first and the free after, so a write
    // and a free of the same name in one cycle leave the entry cleared.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            q_valid   <= '0;
            q_written <= '0;
            q_addr    <= '0;
            head      <= '0;
            owner     <= '0;
        end else if (bus.FLUSH) begin
            q_valid   <= '0;
            q_written <= '0;
            head      <= '0;
            owner     <= '0;
        end else begin
            for (int p = 0; p < 2; p++)
                if (bus.WE[p]) q_written[bus.W_NAME[p]] <= 1'b1;
            if (alloc_fire) begin
                q_valid[head]   <= 1'b1;
                q_written[head] <= 1'b0;
                q_addr[head]    <= bus.ADDR_IN;
                head            <= head + name_width'(1);
            end
            if (free_fire) begin
                q_valid[owner]   <= 1'b0;
                q_written[owner] <= 1'b0;
                owner            <= owner + name_width'(1);
            end
        end
    end

    // Register storage: writes commit even under FLUSH; port 1 is applied
    // last so it wins on a shared address.
    always_ff @(posedge CLK) begin
        for (int p = 0; p < 2; p++)
            if (bus.WE[p]) rf[q_addr[bus.W_NAME[p]]] <= bus.D_IN[p];
    end

    for (genvar c = 0; c < NUM_RD; c++) begin : g_ch
        logic                   match, wh0, wh1, push_valid;
        logic [name_width-1:0]  mname, k;
        logic [data_width-1:0]  push_data;

        // Walk from oldest to newest so the last hit is the youngest writer
        // of this address; a same-cycle alloc is not yet in q_valid.
        always_comb begin
            match = 1'b0;
            mname = '0;
            k     = '0;
            for (int i = 0; i < Q; i++) begin
                k = owner + name_width'(i);
                if (q_valid[k] && (q_addr[k] == bus.RADDR[c])) begin
                    match = 1'b1;
                    mname = k;
                end
            end
        end

        assign wh0 = bus.WE[0] && (bus.W_NAME[0] == mname);
        assign wh1 = bus.WE[1] && (bus.W_NAME[1] == mname);

        always_comb begin
            push_valid = 1'b1;
            push_data  = rf[bus.RADDR[c]];
            if (match && (wh0 || wh1)) begin
                push_data = wh1 ? bus.D_IN[1] : bus.D_IN[0];
            end else if (match && !q_written[mname]) begin
                push_valid = 1'b0;
                push_data  = '0;
            end
        end

        bypass_rf_mp_chan #(
            .data_width (data_width),
            .name_width (name_width),
            .RD_DEPTH   (RD_DEPTH)
        ) u_chan (
            .CLK        (CLK),
            .RST        (RST),
            .flush      (bus.FLUSH),
            .push       (bus.RRESE[c]),
            .push_valid (push_valid),
            .push_name  (mname),
            .push_data  (push_data),
            .pop        (bus.RFREE_E[c]),
            .we         (bus.WE),
            .w_name     (bus.W_NAME),
            .d_in       (bus.D_IN),
            .ready      (bus.RRES_READY[c]),
            .valid_out  (bus.VALID_OUT[c]),
            .d_out      (bus.D_OUT[c])
        );
    end
endmodule

// File: tb/tb_bypass_rf_mp.sv
// Directed bench for bypass_rf_mp. The stimulus process drives one cycle at
// a time (#1 after the rising edge) and queues the output values expected in
// that cycle; a monitor on the falling edge pops and compares them.
module tb_bypass_rf_mp;
    localparam int K_VLD = 0, K_DAT = 1, K_RRDY = 2, K_ARDY = 3, K_NAME = 4, K_FRDY = 5;

    typedef struct {
        int          cyc;
        int          kind;
        int          idx;
        logic [31:0] val;
    } exp_t;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t me;
    logic [31:0] act;

    bypass_rf_mp_if #(.addr_width(5), .data_width(32), .name_width(3), .NUM_RD(3)) bus ();

    bypass_rf_mp #(
        .addr_width(5), .data_width(32), .name_width(3), .NUM_RD(3), .RD_DEPTH(4),
        .binaryInit(0), .file("")
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [31:0] get_act(int kind, int idx);
        case (kind)
            K_VLD:   return 32'(bus.VALID_OUT);
            K_DAT:   return bus.D_OUT[idx];
            K_RRDY:  return 32'(bus.RRES_READY);
            K_ARDY:  return 32'(bus.ALLOC_READY);
            K_NAME:  return 32'(bus.NAME_OUT);
            default: return 32'(bus.F_READY);
        endcase
    endfunction

    function automatic string kname(int kind);
        case (kind)
            K_VLD:   return "VALID_OUT";
            K_DAT:   return "D_OUT";
            K_RRDY:  return "RRES_READY";
            K_ARDY:  return "ALLOC_READY";
            K_NAME:  return "NAME_OUT";
            default: return "F_READY";
        endcase
    endfunction

    // Monitor: compare every expectation queued for the current cycle.
    always @(negedge CLK) begin
        while (sb.size() != 0 && sb[0].cyc <= cyc) begin
            me  = sb.pop_front();
            act = get_act(me.kind, me.idx);
            checks++;
            if (me.cyc != cyc || act !== me.val) begin
                errors++;
                $display("FAIL %s[%0d] cyc %0d: got %h, expected %h", kname(me.kind), me.idx, me.cyc, act, me.val);
            end
        end
    end

    task automatic ex(int kind, int idx, logic [31:0] v);
        exp_t t;
        t.cyc = cyc; t.kind = kind; t.idx = idx; t.val = v;
        sb.push_back(t);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        bus.ALLOC_E = 1'b0; bus.RRESE = '0; bus.WE = '0; bus.RFREE_E = '0;
        bus.WFE = 1'b0; bus.W_F = '0; bus.FLUSH = 1'b0;
    endtask

    task automatic alloc(int a);  bus.ALLOC_E = 1'b1; bus.ADDR_IN = 5'(a); endtask
    task automatic rsv(int c, int a); bus.RRESE[c] = 1'b1; bus.RADDR[c] = 5'(a); endtask
    task automatic wr(int p, int n, logic [31:0] d); bus.WE[p] = 1'b1; bus.W_NAME[p] = 3'(n); bus.D_IN[p] = d; endtask
    task automatic fr(int n);     bus.WFE = 1'b1; bus.W_F = 3'(n); endtask
    task automatic pop(int c);    bus.RFREE_E[c] = 1'b1; endtask

    initial begin
        bus.ALLOC_E = 1'b0; bus.ADDR_IN = '0; bus.RRESE = '0; bus.RADDR = '0;
        bus.WE = '0; bus.W_NAME = '0; bus.D_IN = '0; bus.RFREE_E = '0;
        bus.WFE = 1'b0; bus.W_F = '0; bus.FLUSH = 1'b0;

        // Reset values
        step();
        ex(K_ARDY, 0, 1); ex(K_NAME, 0, 0); ex(K_RRDY, 0, 3'b111);
        ex(K_VLD, 0, 0); ex(K_DAT, 0, 0); ex(K_DAT, 2, 0); ex(K_FRDY, 0, 0);
        step(); RST = 1'b1;

        // 1: seed rf[5]=0x11 (write+free same cycle), then read it back
        step(); alloc(5); ex(K_ARDY, 0, 1); ex(K_NAME, 0, 0);
        step(); wr(0, 0, 32'h11); fr(0); ex(K_FRDY, 0, 1); ex(K_NAME, 0, 1);
        step(); rsv(0, 5); ex(K_VLD, 0, 0);
        step(); pop(0); ex(K_VLD, 0, 3'b001); ex(K_DAT, 0, 32'h11);
        step(); ex(K_VLD, 0, 0); ex(K_DAT, 0, 0);

        // 2: pending read on name 1 (addr 7), 0-cycle head forward, then captured
        step(); alloc(7); ex(K_NAME, 0, 1);
        step(); rsv(1, 7); ex(K_VLD, 0, 0);
        step(); ex(K_VLD, 0, 0);
        step(); wr(0, 1, 32'hAB); ex(K_VLD, 0, 3'b010); ex(K_DAT, 1, 32'hAB);
        step(); pop(1); fr(1); ex(K_VLD, 0, 3'b010); ex(K_DAT, 1, 32'hAB); ex(K_FRDY, 0, 1);
        step(); rsv(0, 7); ex(K_VLD, 0, 0);
        step(); pop(0); ex(K_VLD, 0, 3'b001); ex(K_DAT, 0, 32'hAB);

        // 3: two writers of addr 3 (names 2,3); reader waits on the newest
        step(); alloc(3); ex(K_NAME, 0, 2);
        step(); alloc(3); ex(K_NAME, 0, 3);
        step(); rsv(2, 3); ex(K_VLD, 0, 0);
        step(); wr(0, 2, 32'h77); ex(K_VLD, 0, 0);
        step(); ex(K_VLD, 0, 0);
        step(); wr(1, 3, 32'h5); ex(K_VLD, 0, 3'b100); ex(K_DAT, 2, 32'h5);
        step(); pop(2); fr(2); ex(K_VLD, 0, 3'b100); ex(K_DAT, 2, 32'h5); ex(K_FRDY, 0, 1);
        step(); fr(3); ex(K_FRDY, 0, 1); ex(K_VLD, 0, 0);
        // same-cycle dual write to a reserved name: port 1 wins, captured at push
        step(); alloc(9); ex(K_NAME, 0, 4);
        step(); rsv(1, 9); wr(0, 4, 32'h100); wr(1, 4, 32'h200); ex(K_VLD, 0, 0);
        step(); pop(1); fr(4); ex(K_VLD, 0, 3'b010); ex(K_DAT, 1, 32'h200); ex(K_FRDY, 0, 1);

        // 4: fill ch0, refused push while full, pointer wrap keeps order
        step(); rsv(0, 5); ex(K_RRDY, 0, 3'b111); ex(K_VLD, 0, 0);
        step(); rsv(0, 7); ex(K_VLD, 0, 3'b001); ex(K_DAT, 0, 32'h11);
        step(); rsv(0, 3); ex(K_RRDY, 0, 3'b111);
        step(); rsv(0, 9); ex(K_RRDY, 0, 3'b111);
        step(); rsv(0, 5); pop(0); ex(K_RRDY, 0, 3'b110); ex(K_DAT, 0, 32'h11);
        step(); rsv(0, 7); pop(0); ex(K_RRDY, 0, 3'b111); ex(K_DAT, 0, 32'hAB);
        step(); pop(0); ex(K_RRDY, 0, 3'b111); ex(K_DAT, 0, 32'h5);
        step(); pop(0); ex(K_DAT, 0, 32'h200);
        step(); pop(0); ex(K_VLD, 0, 3'b001); ex(K_DAT, 0, 32'hAB);
        step(); ex(K_VLD, 0, 0); ex(K_RRDY, 0, 3'b111);

        // 5: fill all 8 names (5..7,0..4), out-of-order free ignored
        for (int i = 0; i < 8; i++) begin
            step(); alloc(10 + i); ex(K_ARDY, 0, 1); ex(K_NAME, 0, (5 + i) % 8);
        end
        step(); alloc(31); fr(6); ex(K_ARDY, 0, 0); ex(K_NAME, 0, 5); ex(K_FRDY, 0, 0);
        step(); fr(5); ex(K_ARDY, 0, 0); ex(K_FRDY, 0, 1);
        step(); ex(K_ARDY, 0, 1); ex(K_NAME, 0, 5);

        // 6: pending reads (name 6 @11, name 0 @13), flush with a write
        step(); rsv(0, 11); rsv(1, 13); ex(K_VLD, 0, 0);
        step(); bus.FLUSH = 1'b1; wr(0, 6, 32'h9); ex(K_VLD, 0, 3'b001); ex(K_DAT, 0, 32'h9);
        step(); ex(K_VLD, 0, 0); ex(K_RRDY, 0, 3'b111); ex(K_ARDY, 0, 1); ex(K_NAME, 0, 0); ex(K_FRDY, 0, 0);
        step(); rsv(0, 11); ex(K_VLD, 0, 0);
        step(); pop(0); ex(K_VLD, 0, 3'b001); ex(K_DAT, 0, 32'h9);
        // async reset in the middle of live state
        step(); alloc(20); ex(K_NAME, 0, 0);
        step(); rsv(2, 20); rsv(1, 11); ex(K_VLD, 0, 0);
        step(); ex(K_VLD, 0, 3'b010); ex(K_DAT, 1, 32'h9); ex(K_NAME, 0, 1); ex(K_FRDY, 0, 1);
        step(); RST = 1'b0;
        ex(K_VLD, 0, 0); ex(K_DAT, 1, 0); ex(K_NAME, 0, 0); ex(K_ARDY, 0, 1);
        ex(K_FRDY, 0, 0); ex(K_RRDY, 0, 3'b111);
        step(); RST = 1'b1; ex(K_VLD, 0, 0); ex(K_RRDY, 0, 3'b111); ex(K_NAME, 0, 0);

        repeat (3) step();
        if (sb.size() != 0) begin
            $display("FAIL scoreboard_drain: got %0d unchecked, expected 0", sb.size());
            errors += sb.size();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
